// File: rtl/processor_mc.sv
// Multi-cycle RV32I-subset core: FETCH/EXEC/MEM/WB sequencing with valid/ready fetch,
// req/ack data memory, BNE, immediate logic ops, illegal-opcode flag and retire counter.
module processor_mc #(
    parameter int              XLEN       = 32,
    parameter int              ADDR_WIDTH = 4,
    parameter int              NUM_REGS   = 32,
    parameter int              PC_STEP    = 1,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [31:0]           instruction,
    output logic [XLEN-1:0]       current_PC,
    output logic                  mem_req,
    output logic                  mem_we,
    input  logic                  mem_ack,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [XLEN-1:0]       mem_write_data,
    input  logic [XLEN-1:0]       mem_read_data,
    output logic                  illegal,
    output logic [31:0]           retired
);

    localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_WB} state_t;

    state_t                  state_q;
    logic [31:0]             ir_q;
    logic [XLEN-1:0]         pc_q;
    logic [XLEN-1:0]         alu_q;
    logic [XLEN-1:0]         ld_q;
    logic                    taken_q;
    logic                    wen_q;
    logic                    load_q;
    logic                    illegal_q;
    logic [31:0]             retired_q;
    logic                    mem_req_q;
    logic                    mem_we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [XLEN-1:0]         wdata_q;
    logic [XLEN-1:0]         regs_q [NUM_REGS];

    logic [6:0]              opcode;
    logic [2:0]              funct3;
    logic [RW-1:0]           rd;
    logic [RW-1:0]           rs1;
    logic [RW-1:0]           rs2;
    logic [XLEN-1:0]         rs1_val;
    logic [XLEN-1:0]         rs2_val;
    logic signed [XLEN-1:0]  imm_i;
    logic signed [XLEN-1:0]  imm_s;
    logic signed [XLEN-1:0]  imm_b;
    logic signed [XLEN-1:0]  b_off;
    logic [XLEN-1:0]         alu_d;
    logic                    taken_d;
    logic [XLEN-1:0]         pc_d;

    function automatic logic is_legal(input logic [31:0] ins);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        case (op)
            OP_R:         is_legal = (f3 == 3'b000 && (f7 == 7'h00 || f7 == 7'h20)) ||
                                     ((f3 == 3'b111 || f3 == 3'b110) && f7 == 7'h00);
            OP_I:         is_legal = (f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110);
            OP_LD, OP_ST: is_legal = (f3 == 3'b010);
            OP_BR:        is_legal = (f3 == 3'b000 || f3 == 3'b001);
            default:      is_legal = 1'b0;
        endcase
    endfunction

    assign opcode  = ir_q[6:0];
    assign funct3  = ir_q[14:12];
    assign rd      = ir_q[7 +: RW];
    assign rs1     = ir_q[15 +: RW];
    assign rs2     = ir_q[20 +: RW];
    assign rs1_val = regs_q[rs1];
    assign rs2_val = regs_q[rs2];

    assign imm_i = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    // Word-indexed PCs count instructions, so the byte offset is scaled down by 4.
    assign b_off = (PC_STEP == 4) ? imm_b : (imm_b >>> 2);

    always_comb begin
        alu_d   = '0;
        taken_d = 1'b0;
        case (opcode)
            OP_R: begin
                case (funct3)
                    3'b000:  alu_d = ir_q[30] ? (rs1_val - rs2_val) : (rs1_val + rs2_val);
                    3'b111:  alu_d = rs1_val & rs2_val;
                    3'b110:  alu_d = rs1_val | rs2_val;
                    default: alu_d = '0;
                endcase
            end
            OP_I: begin
                case (funct3)
                    3'b000:  alu_d = rs1_val + $unsigned(imm_i);
                    3'b111:  alu_d = rs1_val & $unsigned(imm_i);
                    3'b110:  alu_d = rs1_val | $unsigned(imm_i);
                    default: alu_d = '0;
                endcase
            end
            OP_LD:   alu_d = rs1_val + $unsigned(imm_i);
            OP_ST:   alu_d = rs1_val + $unsigned(imm_s);
            OP_BR:   taken_d = funct3[0] ? (rs1_val != rs2_val) : (rs1_val == rs2_val);
            default: alu_d = '0;
        endcase
    end

    assign pc_d = taken_q ? (pc_q + $unsigned(b_off)) : (pc_q + XLEN'(PC_STEP));

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            pc_q      <= RESET_PC;
            alu_q     <= '0;
            ld_q      <= '0;
            taken_q   <= 1'b0;
            wen_q     <= 1'b0;
            load_q    <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= '0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            illegal_q <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    if (instr_valid) begin
                        ir_q      <= instruction;
                        illegal_q <= !is_legal(instruction);
                        state_q   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // illegal_q still holds this instruction's decode verdict here.
                    alu_q   <= alu_d;
                    taken_q <= taken_d && !illegal_q;
                    load_q  <= (opcode == OP_LD);
                    wen_q   <= !illegal_q && (rd != '0) &&
                               (opcode == OP_R || opcode == OP_I || opcode == OP_LD);
                    if (!illegal_q && (opcode == OP_LD || opcode == OP_ST)) begin
                        mem_req_q <= 1'b1;
                        mem_we_q  <= (opcode == OP_ST);
                        addr_q    <= alu_d[ADDR_WIDTH-1:0];
                        wdata_q   <= rs2_val;
                        state_q   <= S_MEM;
                    end else begin
                        state_q   <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (!mem_we_q) begin
                            ld_q <= mem_read_data;
                        end
                        state_q   <= S_WB;
                    end
                end
                S_WB: begin
                    if (wen_q) begin
                        regs_q[rd] <= load_q ? ld_q : alu_q;
                    end
                    pc_q      <= pc_d;
                    retired_q <= retired_q + 32'd1;
                    state_q   <= S_FETCH;
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Gated with rst so ready drops the moment reset is asserted.
    assign instr_ready    = (state_q == S_FETCH) && rst;
    assign current_PC     = pc_q;
    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign address        = addr_q;
    assign mem_write_data = wdata_q;
    assign illegal        = illegal_q;
    assign retired        = retired_q;

endmodule
